// File: rtl/mipi_hsrx_pkg.sv
// Shared types and SoT leader helpers for the MIPI HS receive lane aligner.
package mipi_hsrx_pkg;

   localparam logic [7:0] SOT_LEADER = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAIL   = 2'd3
   } lane_state_e;

   function automatic logic leader_err1(input logic [7:0] cand);
      return $countones(cand ^ SOT_LEADER) == 1;
   endfunction

endpackage

// File: rtl/mipi_hsrx_lane_sync.sv
// Per-lane SoT hunt, bit-offset alignment and deskew FIFO.
//   state     | meaning
//   ST_IDLE   | lane disabled or just enabled, nothing tracked
//   ST_HUNT   | searching the 2-word window for the SoT leader
//   ST_LOCKED | offset latched, aligned words pushed into the FIFO
//   ST_FAIL   | leader never seen within the timeout, lane excluded
module mipi_hsrx_lane_sync
   import mipi_hsrx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int SYNC_TIMEOUT = 16,
   parameter int DESKEW_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rxhsen,
   input  logic             raw_valid,
   input  logic [WIDTH-1:0] raw_data,
   input  logic             pop,
   output logic             sync,
   output logic             errsync,
   output logic             nosync,
   output logic             locked,
   output logic             hunting,
   output logic             fifo_empty,
   output logic [WIDTH-1:0] fifo_head,
   output logic             ovf
);
   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TW = $clog2(SYNC_TIMEOUT + 1);
   localparam int AW = (DESKEW_DEPTH > 1) ? $clog2(DESKEW_DEPTH) : 1;
   localparam int CW = $clog2(DESKEW_DEPTH + 1);

   lane_state_e        state;
   logic [WIDTH-1:0]   prev;
   logic [2*WIDTH-1:0] window;
   logic [KW-1:0]      offset;
   logic [TW-1:0]      tmr;
   logic               exact_hit, err_hit;
   logic [KW-1:0]      exact_k, err_k;
   logic [WIDTH-1:0]   aligned;

   logic [WIDTH-1:0]   mem [DESKEW_DEPTH];
   logic [AW-1:0]      wptr, rptr;
   logic [CW-1:0]      count;
   logic               wr, full, do_wr, do_pop;

   assign window  = {raw_data, prev};
   assign aligned = window[offset +: WIDTH];
   assign locked  = (state == ST_LOCKED);
   assign hunting = (state == ST_HUNT);

   // Scan high to low so the lowest matching offset is the one left standing.
   always_comb begin
      exact_hit = 1'b0;
      exact_k   = '0;
      err_hit   = 1'b0;
      err_k     = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (window[k +: 8] == SOT_LEADER) begin
            exact_hit = 1'b1;
            exact_k   = KW'(k);
         end
         if (leader_err1(window[k +: 8])) begin
            err_hit = 1'b1;
            err_k   = KW'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         prev    <= '0;
         offset  <= '0;
         tmr     <= '0;
         sync    <= 1'b0;
         errsync <= 1'b0;
         nosync  <= 1'b0;
      end else begin
         if (raw_valid) prev <= raw_data;
         if (!rxhsen) begin
            state   <= ST_IDLE;
            sync    <= 1'b0;
            errsync <= 1'b0;
            nosync  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_HUNT;
                  tmr   <= TW'(SYNC_TIMEOUT);
               end
               ST_HUNT: begin
                  if (raw_valid) begin
                     if (exact_hit) begin
                        state  <= ST_LOCKED;
                        offset <= exact_k;
                        sync   <= 1'b1;
                     end else if (err_hit) begin
                        state   <= ST_LOCKED;
                        offset  <= err_k;
                        errsync <= 1'b1;
                     end else if (tmr <= TW'(1)) begin
                        state  <= ST_FAIL;
                        nosync <= 1'b1;
                     end else begin
                        tmr <= tmr - TW'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DESKEW_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign wr         = rxhsen && locked && raw_valid;
   assign full       = (count == CW'(DESKEW_DEPTH));
   assign fifo_empty = (count == '0);
   assign do_pop     = pop && !fifo_empty;
   assign do_wr      = wr && (!full || do_pop);
   assign ovf        = wr && full && !do_pop;
   assign fifo_head  = mem[rptr];

   // Dropping the enable discards anything still queued for this lane.
   always_ff @(posedge clk) begin
      if (!rst_n || !rxhsen) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr)  wptr <= ptr_inc(wptr);
         if (do_pop) rptr <= ptr_inc(rptr);
         if (do_wr && !do_pop)      count <= count + CW'(1);
         else if (!do_wr && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= aligned;
   end

endmodule

// File: rtl/mipi_hsrx_lane_align.sv
// Multi-lane HS receive aligner: per-lane sync/align plus cross-lane deskew pop.
module mipi_hsrx_lane_align
   import mipi_hsrx_pkg::*;
#(
   parameter int LANES        = 2,
   parameter int WIDTH        = 8,
   parameter int SYNC_TIMEOUT = 16,
   parameter int DESKEW_DEPTH = 4
) (
   input  logic                   HS_BYTE_CLK,
   input  logic                   RST_N,
   input  logic [LANES-1:0]       RXHSEN,
   input  logic [LANES*WIDTH-1:0] RAW_DATA,
   input  logic [LANES-1:0]       RAW_VALID,
   output logic [LANES*WIDTH-1:0] HSRX_DATA,
   output logic                   HSRX_VALID,
   output logic [LANES-1:0]       SYNC,
   output logic [LANES-1:0]       ERRSYNC,
   output logic [LANES-1:0]       NOSYNC,
   output logic                   SKEW_ERR
);
   logic [LANES-1:0]       locked, hunting, empty, ovf, active, pop;
   logic [WIDTH-1:0]       head [LANES];
   logic                   pop_all;
   logic [LANES*WIDTH-1:0] data_d;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mipi_hsrx_lane_sync #(
         .WIDTH        (WIDTH),
         .SYNC_TIMEOUT (SYNC_TIMEOUT),
         .DESKEW_DEPTH (DESKEW_DEPTH)
      ) u_sync (
         .clk        (HS_BYTE_CLK),
         .rst_n      (RST_N),
         .rxhsen     (RXHSEN[i]),
         .raw_valid  (RAW_VALID[i]),
         .raw_data   (RAW_DATA[i*WIDTH +: WIDTH]),
         .pop        (pop[i]),
         .sync       (SYNC[i]),
         .errsync    (ERRSYNC[i]),
         .nosync     (NOSYNC[i]),
         .locked     (locked[i]),
         .hunting    (hunting[i]),
         .fifo_empty (empty[i]),
         .fifo_head  (head[i]),
         .ovf        (ovf[i])
      );
   end

   // A lane still hunting may yet lock, so nothing leaves until it decides.
   assign active  = RXHSEN & locked;
   assign pop_all = (|active) && !(|(RXHSEN & hunting)) && !(|(active & empty));
   assign pop     = active & {LANES{pop_all}};

   always_comb begin
      data_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (pop[i]) data_d[i*WIDTH +: WIDTH] = head[i];
      end
   end

   always_ff @(posedge HS_BYTE_CLK) begin
      if (!RST_N) begin
         HSRX_VALID <= 1'b0;
         HSRX_DATA  <= '0;
         SKEW_ERR   <= 1'b0;
      end else begin
         HSRX_VALID <= pop_all;
         HSRX_DATA  <= data_d;
         if (RXHSEN == '0) SKEW_ERR <= 1'b0;
         else if (|ovf)    SKEW_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mipi_hsrx_lane_align.sv
// Bench for mipi_hsrx_lane_align: bit-stream built from leader/payload, expected words from payload lists.
module tb_mipi_hsrx_lane_align;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rxhsen, raw_valid;
   logic [15:0] raw_data;
   logic [15:0] hsrx_data;
   logic        hsrx_valid;
   logic [1:0]  sync, errsync, nosync;
   logic        skew_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  pay0_q[$], pay1_q[$], raw0_q[$], raw1_q[$];
   int          drv_cyc0[$], drv_cyc1[$];
   logic [15:0] out_q[$];
   int          out_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mipi_hsrx_lane_align #(
      .LANES(2), .WIDTH(8), .SYNC_TIMEOUT(16), .DESKEW_DEPTH(4)
   ) dut (
      .HS_BYTE_CLK (clk),
      .RST_N       (rst_n),
      .RXHSEN      (rxhsen),
      .RAW_DATA    (raw_data),
      .RAW_VALID   (raw_valid),
      .HSRX_DATA   (hsrx_data),
      .HSRX_VALID  (hsrx_valid),
      .SYNC        (sync),
      .ERRSYNC     (errsync),
      .NOSYNC      (nosync),
      .SKEW_ERR    (skew_err)
   );

   always @(negedge clk) begin
      if (hsrx_valid) begin
         out_q.push_back(hsrx_data);
         out_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Serial stream: k filler zeros, leader, payload (LSB first), chopped into words.
   function automatic void build(input int lane, input int k, input logic [7:0] leader);
      logic       bits[$];
      logic [7:0] pay[$];
      logic [7:0] raw[$];
      pay = (lane == 0) ? pay0_q : pay1_q;
      for (int i = 0; i < k; i++) bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(leader[b]);
      foreach (pay[m]) for (int b = 0; b < 8; b++) bits.push_back(pay[m][b]);
      for (int j = 0; j < pay.size() + 2; j++) begin
         logic [7:0] w;
         w = '0;
         for (int b = 0; b < 8; b++) if (j*8 + b < bits.size()) w[b] = bits[j*8 + b];
         raw.push_back(w);
      end
      if (lane == 0) raw0_q = raw; else raw1_q = raw;
   endfunction

   function automatic void rand_pay(input int n);
      pay0_q = {}; pay1_q = {};
      for (int i = 0; i < n; i++) begin
         pay0_q.push_back(8'($urandom_range(0, 255)));
         pay1_q.push_back(8'($urandom_range(0, 255)));
      end
   endfunction

   task automatic start(input logic [1:0] en);
      @(posedge clk); #1;
      rst_n = 1'b0; rxhsen = 2'b00; raw_valid = 2'b00; raw_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1; rxhsen = en;
      out_q = {}; out_cyc = {};
      raw0_q = {}; raw1_q = {}; pay0_q = {}; pay1_q = {};
   endtask

   task automatic drive(input int lag0, input int lag1, input int stop_at);
      int len;
      len = raw0_q.size() + lag0;
      if (raw1_q.size() + lag1 > len) len = raw1_q.size() + lag1;
      drv_cyc0 = {}; drv_cyc1 = {};
      for (int i = 0; i < len && i < stop_at; i++) begin
         @(posedge clk); #1;
         raw_valid = 2'b00; raw_data = '0;
         if (i >= lag0 && i - lag0 < raw0_q.size()) begin
            raw_valid[0] = 1'b1; raw_data[7:0] = raw0_q[i - lag0]; drv_cyc0.push_back(cyc);
         end
         if (i >= lag1 && i - lag1 < raw1_q.size()) begin
            raw_valid[1] = 1'b1; raw_data[15:8] = raw1_q[i - lag1]; drv_cyc1.push_back(cyc);
         end
      end
      @(posedge clk); #1;
      raw_valid = 2'b00; raw_data = '0;
   endtask

   task automatic check_out(input string tag, input logic [1:0] en);
      int n;
      repeat (8) @(posedge clk);
      #1;
      n = en[0] ? pay0_q.size() : pay1_q.size();
      chk({tag, "_cnt"}, 32'(out_q.size()), 32'(n));
      for (int m = 0; m < n && m < out_q.size(); m++) begin
         logic [15:0] e;
         int          ec;
         e = '0; ec = 0;
         if (en[0]) begin e[7:0] = pay0_q[m]; ec = drv_cyc0[m + 2]; end
         if (en[1]) begin e[15:8] = pay1_q[m]; if (drv_cyc1[m + 2] > ec) ec = drv_cyc1[m + 2]; end
         chk({tag, "_data"}, 32'(out_q[m]), 32'(e));
         chk({tag, "_lat"}, 32'(out_cyc[m]), 32'(ec + 2));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int k0, k1, lag, n;
      rst_n = 1'b0; rxhsen = 2'b11; raw_valid = 2'b11; raw_data = 16'hB8B8;
      @(posedge clk); #1;
      chk("reset_outs", 32'({hsrx_valid, hsrx_data, sync, errsync, nosync, skew_err}), 32'd0);

      // Both lanes, leader at bit offset 3, two payload words.
      start(2'b11);
      pay0_q = '{8'h11, 8'h22}; pay1_q = '{8'h11, 8'h22};
      build(0, 3, 8'hB8); build(1, 3, 8'hB8);
      drive(0, 0, 1000);
      chk("basic_sync", 32'(sync), 32'd3);
      chk("basic_errsync", 32'(errsync), 32'd0);
      check_out("basic", 2'b11);

      // Lane 1 leader carries a single bit error.
      start(2'b11);
      pay0_q = '{8'h5A, 8'hC3, 8'h0F}; pay1_q = '{8'hA5, 8'h3C, 8'hF0};
      build(0, int'($urandom_range(0, 7)), 8'hB8); build(1, 0, 8'hB9);
      drive(0, 0, 1000);
      chk("err_sync", 32'(sync), 32'd1);
      chk("err_errsync", 32'(errsync), 32'd2);
      check_out("errsync", 2'b11);

      // Lane 0 never sees a leader; NOSYNC must wait for exactly 16 words.
      start(2'b11);
      for (int i = 0; i < 15; i++) raw0_q.push_back(8'h00);
      drive(0, 0, 1000);
      chk("nosync_15", 32'(nosync), 32'd0);
      raw0_q = '{8'h00};
      drive(0, 0, 1000);
      chk("nosync_16", 32'(nosync), 32'd1);
      raw0_q = {};
      pay1_q = '{8'h77, 8'h88, 8'h99};
      build(1, int'($urandom_range(0, 7)), 8'hB8);
      drive(0, 0, 1000);
      chk("nosync_sync1", 32'(sync), 32'd2);
      check_out("nosync", 2'b10);

      // Lane 1 two words behind lane 0: aligned output, no overflow.
      start(2'b11);
      rand_pay(6);
      build(0, 5, 8'hB8); build(1, 2, 8'hB8);
      drive(0, 2, 1000);
      check_out("lag2", 2'b11);
      chk("lag2_skew", 32'(skew_err), 32'd0);

      // Five words of lag overflows a 4-deep FIFO; error sticks until all lanes off.
      start(2'b11);
      rand_pay(8);
      build(0, 1, 8'hB8); build(1, 6, 8'hB8);
      drive(0, 5, 1000);
      repeat (4) @(posedge clk);
      #1;
      chk("lag5_skew", 32'(skew_err), 32'd1);
      rxhsen = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      chk("lag5_skew_hold", 32'(skew_err), 32'd1);
      rxhsen = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("lag5_skew_clear", 32'(skew_err), 32'd0);

      // Reset in the middle of a packet, then a fresh SoT.
      start(2'b11);
      rand_pay(8);
      build(0, 2, 8'hB8); build(1, 7, 8'hB8);
      drive(0, 0, 5);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_outs", 32'({hsrx_valid, hsrx_data, sync, errsync, nosync, skew_err}), 32'd0);
      rst_n = 1'b1;
      out_q = {}; out_cyc = {};
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_quiet", 32'(out_q.size()), 32'd0);
      rand_pay(4);
      build(0, 4, 8'hB8); build(1, 0, 8'hB8);
      drive(0, 0, 1000);
      chk("midrst_sync", 32'(sync), 32'd3);
      check_out("midrst", 2'b11);

      // Randomized offsets, payloads and lag within FIFO capacity.
      for (int it = 0; it < 8; it++) begin
         start(2'b11);
         n   = int'($urandom_range(3, 8));
         k0  = int'($urandom_range(0, 7));
         k1  = int'($urandom_range(0, 7));
         lag = int'($urandom_range(0, 3));
         rand_pay(n);
         build(0, k0, 8'hB8); build(1, k1, 8'hB8);
         if ($urandom_range(0, 1) == 0) drive(lag, 0, 1000);
         else                           drive(0, lag, 1000);
         chk("rand_sync", 32'(sync), 32'd3);
         check_out("rand", 2'b11);
         chk("rand_skew", 32'(skew_err), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
